disparity_engine: RTL and testbench
===================================

Name: disparity_engine

Overview:
- Stereo block-matching engine: reads a WIDTH×HEIGHT 8-bit left and right image from an external frame buffer, then computes a per-block disparity map by minimum sum of absolute differences (SAD).
- Sits between the dual-image capture buffer and the display path.
- The display path reads the finished map through disp_href/disp_vref → new_image.

Parameters:
- WIDTH, 20, image width in pixels
- HEIGHT, 7, image height in pixels
- BLOCK, 3, square block edge in pixels
- MAXDISP, 4, number of candidate disparities (0..MAXDISP-1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start pulse; sampled in IDLE only
- image_data  in  8  pixel at {image_sel, buffer_vref, buffer_href}; combinational, valid in same cycle
- buffer_ready  in  1  frame buffer valid; READ stalls while low
- disp_href  in  10  map readout block column
- disp_vref  in  10  map readout block row
- new_image  out  8  map value at (disp_vref, disp_href), registered
- buffer_href  out  10  frame-buffer column address
- buffer_vref  out  10  frame-buffer row address
- image_sel  out  1  1 = left image, 0 = right image
- idle  out  1  high in IDLE
- state_LED  out  3  current state code
- minr, maxr  out  10  pixel rows of current block
- t_minc, t_maxc  out  10  template (left) block columns
- b_minc, b_maxc  out  10  search (right) block columns
- mind, maxd  out  10  constants 0 and MAXDISP-1
- numBlocks  out  10  constant (WIDTH/BLOCK)*(HEIGHT/BLOCK)
- rcnt, ccnt  out  10  row/column offset inside block during SAD
- dcnt  out  10  current disparity
- cdcnt, rdcnt  out  10  current block column/row index
- scnt  out  10  SAD pixel step (0..BLOCK*BLOCK-1)

Behaviour:
- State encoding: IDLE=000, READ=001, SEPARATE=010, SAD=011, FINALIZE=100. state_LED shows the current state.
- Reset (async):
  - state IDLE; idle=1.
  - All address, counter and debug registers 0, except constants mind=0, maxd=MAXDISP-1 and numBlocks.
  - Map cleared to 0; new_image=0.
  - Reset mid-operation aborts immediately.
- IDLE: when enable=1 and buffer_ready=1, go to READ. enable is ignored in all other states.
- READ:
  - Copy image_sel=1 (left) first, then image_sel=0 (right), row-major, one pixel per cycle.
  - image_data is captured on the edge that advances the address.
  - Address holds while buffer_ready=0.
  - After the last right pixel, go to SEPARATE with block (0,0) and dcnt=0.
  - Minimum duration 2*WIDTH*HEIGHT cycles (280 at defaults).
- Blocks: only full blocks are used (cdcnt < WIDTH/BLOCK, rdcnt < HEIGHT/BLOCK); partial edge pixels are ignored.
- SEPARATE (1 cycle):
  - minr=rdcnt*BLOCK, maxr=minr+BLOCK-1.
  - t_minc=cdcnt*BLOCK, t_maxc=t_minc+BLOCK-1.
  - b_minc=t_minc-dcnt, b_maxc=b_minc+BLOCK-1.
  - If t_minc < dcnt, the disparity is invalid: go to FINALIZE. Otherwise clear the accumulator and go to SAD.
- SAD (BLOCK*BLOCK cycles):
  - Each cycle add |L(minr+rcnt, t_minc+ccnt) - R(minr+rcnt, b_minc+ccnt)| to a 16-bit accumulator.
  - scnt increments; ccnt wraps at BLOCK and then increments rcnt.
  - On the last step, compare the sum with the best SAD so far. Strictly smaller wins, so ties keep the lower d. d=0 always initialises the best.
  - If dcnt < MAXDISP-1: increment dcnt and go to SEPARATE. Else go to FINALIZE.
- FINALIZE (1 cycle):
  - Write the best d to map[rdcnt][cdcnt].
  - Advance cdcnt, wrapping to the next rdcnt; reset dcnt=0.
  - Go to SEPARATE, or to IDLE after the last block.
- new_image: registered map[disp_vref][disp_href] every cycle in any state; 0 if either index is out of range.

Optional Feature:
- Macro DISPARITY_SCALE_EN.
- Defined: stored value is best_d*(255/(MAXDISP-1)), so the defaults give 0/85/170/255.
- Undefined: stored value is raw best_d.

Decomposition:
- disparity_pkg holds:
  - state encodings
  - COORD_W=10
  - PIX_W=8
  - SAD_W=16
- One natural sub-module, sad_unit: abs-diff accumulator plus best-SAD/best-d tracker, with clear, accumulate and commit strobes.

Test Plan:
- Reset pulse → state_LED=000, idle=1, numBlocks=12, maxd=3, new_image=0 for all disp_href/disp_vref.
- Identical images, enable 1-cycle pulse → READ lasts 280 cycles. FINALIZE is entered exactly 12 times, then IDLE. Every map entry reads 0 (scale on or off).
- Textured left L(x,y)=(37x+11y) mod 256; right R(x,y)=L(x+2,y). Expected map:
  - cdcnt≥1 → 2 (170 with DISPARITY_SCALE_EN).
  - cdcnt=0 → 0.
- buffer_ready low for 10 cycles during READ → buffer_href/buffer_vref frozen; READ lasts 290 cycles; map identical to the unstalled run.
- Reset asserted while state_LED=011 → next sample state_LED=000; map cleared; a fresh enable reproduces the full result.
- enable pulsed during SAD → no restart. Sequence, block count and final map are unchanged.

Source files
------------

// File: rtl/disparity_pkg.sv
// Shared types and widths for the stereo disparity engine.
package disparity_pkg;
  localparam int COORD_W = 10;
  localparam int PIX_W   = 8;
  localparam int SAD_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_READ     = 3'b001,
    ST_SEPARATE = 3'b010,
    ST_SAD      = 3'b011,
    ST_FINALIZE = 3'b100
  } state_t;
endpackage

// File: rtl/disparity_engine_if.sv
// Frame-buffer fetch bus and disparity-map readout bus of the disparity engine.
// Fetch: engine drives {image_sel, buffer_vref, buffer_href}; image_data answers in the same
// cycle and a pixel transfers on a rising edge only while buffer_ready is high.
interface disparity_engine_if;
  import disparity_pkg::*;

  logic [PIX_W-1:0]   image_data;
  logic               buffer_ready;
  logic [COORD_W-1:0] buffer_href;
  logic [COORD_W-1:0] buffer_vref;
  logic               image_sel;
  logic [COORD_W-1:0] disp_href;
  logic [COORD_W-1:0] disp_vref;
  logic [PIX_W-1:0]   new_image;

  modport master (
    input  image_data, buffer_ready, disp_href, disp_vref,
    output buffer_href, buffer_vref, image_sel, new_image
  );

  modport slave (
    output image_data, buffer_ready, disp_href, disp_vref,
    input  buffer_href, buffer_vref, image_sel, new_image
  );
endinterface

// File: rtl/disparity_engine_sad_unit.sv
// Absolute-difference accumulator with best-SAD / best-disparity tracking.
module disparity_engine_sad_unit
  import disparity_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               accumulate,
  input  logic               commit,
  input  logic [PIX_W-1:0]   left_pix,
  input  logic [PIX_W-1:0]   right_pix,
  input  logic [COORD_W-1:0] d,
  output logic [COORD_W-1:0] best_d
);
  logic [SAD_W-1:0] acc;
  logic [SAD_W-1:0] sum_next;
  logic [SAD_W-1:0] best_sad;
  logic [PIX_W-1:0] abs_diff;

  always_comb begin
    abs_diff = (left_pix >= right_pix) ? (left_pix - right_pix) : (right_pix - left_pix);
    sum_next = acc + SAD_W'(abs_diff);
  end

  // commit sees the sum including the final pixel; d==0 always seeds the best
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      best_sad <= '0;
      best_d   <= '0;
    end else begin
      if (clear)
        acc <= '0;
      else if (accumulate)
        acc <= sum_next;
      if (commit && ((d == '0) || (sum_next < best_sad))) begin
        best_sad <= sum_next;
        best_d   <= d;
      end
    end
  end
endmodule

// File: rtl/disparity_engine.sv
// Stereo block-matching engine: fetches left/right frames, emits a min-SAD disparity map.
// Optional macro DISPARITY_SCALE_EN stores best_d scaled to the full 8-bit range.
module disparity_engine
  import disparity_pkg::*;
#(
  parameter int WIDTH   = 20,
  parameter int HEIGHT  = 7,
  parameter int BLOCK   = 3,
  parameter int MAXDISP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  disparity_engine_if.master bus,
  output logic               idle,
  output logic [2:0]         state_LED,
  output logic [COORD_W-1:0] minr,
  output logic [COORD_W-1:0] maxr,
  output logic [COORD_W-1:0] t_minc,
  output logic [COORD_W-1:0] t_maxc,
  output logic [COORD_W-1:0] b_minc,
  output logic [COORD_W-1:0] b_maxc,
  output logic [COORD_W-1:0] mind,
  output logic [COORD_W-1:0] maxd,
  output logic [COORD_W-1:0] numBlocks,
  output logic [COORD_W-1:0] rcnt,
  output logic [COORD_W-1:0] ccnt,
  output logic [COORD_W-1:0] dcnt,
  output logic [COORD_W-1:0] cdcnt,
  output logic [COORD_W-1:0] rdcnt,
  output logic [COORD_W-1:0] scnt
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int BCOLS = WIDTH / BLOCK;
  localparam int BROWS = HEIGHT / BLOCK;
  localparam int NBLK  = BCOLS * BROWS;
  localparam int STEPS = BLOCK * BLOCK;
  localparam int AW    = $clog2(NPIX);
  localparam int MW    = $clog2(NBLK);

  state_t state, state_next;

  logic [PIX_W-1:0]   left_img  [NPIX];
  logic [PIX_W-1:0]   right_img [NPIX];
  logic [PIX_W-1:0]   map       [NBLK];

  logic [COORD_W-1:0] href, vref;
  logic               sel;
  logic [AW-1:0]      wr_idx, l_idx, r_idx;
  logic [MW-1:0]      map_idx, rd_idx;
  logic [COORD_W-1:0] sep_minr, sep_t_minc, best_d;
  logic [PIX_W-1:0]   map_wr_val;
  logic               last_pix, sep_invalid, last_step, last_block, rd_in_range;

  assign bus.buffer_href = href;
  assign bus.buffer_vref = vref;
  assign bus.image_sel   = sel;
  assign state_LED       = state;
  assign idle            = (state == ST_IDLE);
  assign mind            = '0;
  assign maxd            = COORD_W'(MAXDISP - 1);
  assign numBlocks       = COORD_W'(NBLK);

  always_comb begin
    wr_idx      = AW'(32'(vref) * WIDTH + 32'(href));
    l_idx       = AW'(32'(minr + rcnt) * WIDTH + 32'(t_minc + ccnt));
    r_idx       = AW'(32'(minr + rcnt) * WIDTH + 32'(b_minc + ccnt));
    map_idx     = MW'(32'(rdcnt) * BCOLS + 32'(cdcnt));
    rd_idx      = MW'(32'(bus.disp_vref) * BCOLS + 32'(bus.disp_href));
    rd_in_range = (bus.disp_vref < COORD_W'(BROWS)) && (bus.disp_href < COORD_W'(BCOLS));
    sep_minr    = COORD_W'(32'(rdcnt) * BLOCK);
    sep_t_minc  = COORD_W'(32'(cdcnt) * BLOCK);
    sep_invalid = (sep_t_minc < dcnt);
    last_pix    = !sel && (vref == COORD_W'(HEIGHT - 1)) && (href == COORD_W'(WIDTH - 1));
    last_step   = (scnt == COORD_W'(STEPS - 1));
    last_block  = (cdcnt == COORD_W'(BCOLS - 1)) && (rdcnt == COORD_W'(BROWS - 1));
  end

`ifdef DISPARITY_SCALE_EN
  assign map_wr_val = PIX_W'(32'(best_d) * (255 / (MAXDISP - 1)));
`else
  assign map_wr_val = PIX_W'(best_d);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (enable && bus.buffer_ready) state_next = ST_READ;
      ST_READ:     if (bus.buffer_ready && last_pix) state_next = ST_SEPARATE;
      ST_SEPARATE: state_next = sep_invalid ? ST_FINALIZE : ST_SAD;
      ST_SAD:      if (last_step)
                     state_next = (dcnt < COORD_W'(MAXDISP - 1)) ? ST_SEPARATE : ST_FINALIZE;
      ST_FINALIZE: state_next = last_block ? ST_IDLE : ST_SEPARATE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // frame storage is plain memory; contents are only meaningful after a full READ
  always_ff @(posedge clk) begin
    if (state == ST_READ && bus.buffer_ready) begin
      if (sel) left_img[wr_idx]  <= bus.image_data;
      else     right_img[wr_idx] <= bus.image_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      href <= '0; vref <= '0; sel <= 1'b0;
      minr <= '0; maxr <= '0; t_minc <= '0; t_maxc <= '0; b_minc <= '0; b_maxc <= '0;
      rcnt <= '0; ccnt <= '0; dcnt <= '0; cdcnt <= '0; rdcnt <= '0; scnt <= '0;
      bus.new_image <= '0;
      for (int i = 0; i < NBLK; i++) map[i] <= '0;
    end else begin
      bus.new_image <= rd_in_range ? map[rd_idx] : '0;
      case (state)
        ST_IDLE: if (state_next == ST_READ) begin
          href <= '0; vref <= '0; sel <= 1'b1;
          cdcnt <= '0; rdcnt <= '0; dcnt <= '0;
        end
        ST_READ: if (bus.buffer_ready) begin
          if (href == COORD_W'(WIDTH - 1)) begin
            href <= '0;
            if (vref == COORD_W'(HEIGHT - 1)) begin
              vref <= '0;
              sel  <= 1'b0;
            end else begin
              vref <= vref + 1'b1;
            end
          end else begin
            href <= href + 1'b1;
          end
        end
        ST_SEPARATE: begin
          minr   <= sep_minr;
          maxr   <= sep_minr + COORD_W'(BLOCK - 1);
          t_minc <= sep_t_minc;
          t_maxc <= sep_t_minc + COORD_W'(BLOCK - 1);
          b_minc <= sep_t_minc - dcnt;
          b_maxc <= sep_t_minc - dcnt + COORD_W'(BLOCK - 1);
          rcnt <= '0; ccnt <= '0; scnt <= '0;
        end
        ST_SAD: begin
          scnt <= scnt + 1'b1;
          if (ccnt == COORD_W'(BLOCK - 1)) begin
            ccnt <= '0;
            rcnt <= rcnt + 1'b1;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
          if (last_step && (dcnt < COORD_W'(MAXDISP - 1))) dcnt <= dcnt + 1'b1;
        end
        ST_FINALIZE: begin
          map[map_idx] <= map_wr_val;
          dcnt <= '0;
          if (cdcnt == COORD_W'(BCOLS - 1)) begin
            cdcnt <= '0;
            rdcnt <= last_block ? '0 : rdcnt + 1'b1;
          end else begin
            cdcnt <= cdcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  disparity_engine_sad_unit u_sad (
    .clk        (clk),
    .rst        (reset),
    .clear      (state == ST_SEPARATE),
    .accumulate (state == ST_SAD),
    .commit     ((state == ST_SAD) && last_step),
    .left_pix   (left_img[l_idx]),
    .right_pix  (right_img[r_idx]),
    .d          (dcnt),
    .best_d     (best_d)
  );
endmodule

// File: tb/tb_disparity_engine.sv
// Directed bench for disparity_engine: frame-buffer model, run monitor, map scoreboard.
module tb_disparity_engine;
  import disparity_pkg::*;

  localparam int BCOLS = 6;
  localparam int BROWS = 2;
  localparam int NPIX  = 140;
`ifdef DISPARITY_SCALE_EN
  localparam int EXP_SHIFTED = 170;
`else
  localparam int EXP_SHIFTED = 2;
`endif

  logic clk = 1'b0;
  logic reset, enable;
  logic idle;
  logic [2:0] state_LED;
  logic [9:0] minr, maxr, t_minc, t_maxc, b_minc, b_maxc, mind, maxd, numBlocks;
  logic [9:0] rcnt, ccnt, dcnt, cdcnt, rdcnt, scnt;
  int mode;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  disparity_engine_if bus();

  disparity_engine dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus.master),
    .idle(idle), .state_LED(state_LED),
    .minr(minr), .maxr(maxr), .t_minc(t_minc), .t_maxc(t_maxc),
    .b_minc(b_minc), .b_maxc(b_maxc), .mind(mind), .maxd(maxd), .numBlocks(numBlocks),
    .rcnt(rcnt), .ccnt(ccnt), .dcnt(dcnt), .cdcnt(cdcnt), .rdcnt(rdcnt), .scnt(scnt)
  );

  function automatic logic [7:0] lpix(input int x, input int y);
    return 8'((37 * x + 11 * y) % 256);
  endfunction

  // frame buffer: mode 0 identical images, mode 1 right = left shifted by 2 columns
  always_comb begin
    if (bus.image_sel || mode == 0)
      bus.image_data = lpix(int'(bus.buffer_href), int'(bus.buffer_vref));
    else
      bus.image_data = lpix(int'(bus.buffer_href) + 2, int'(bus.buffer_vref));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic read_map(input int h, input int v, output logic [7:0] val);
    @(negedge clk);
    bus.disp_href = 10'(h);
    bus.disp_vref = 10'(v);
    @(negedge clk);
    val = bus.new_image;
  endtask

  // scoreboard: queue the expected map, then read back every entry plus out-of-range probes
  task automatic check_map(input string tag, input bit shifted);
    logic [7:0] got;
    for (int v = 0; v < BROWS; v++)
      for (int h = 0; h < BCOLS; h++)
        exp_q.push_back((shifted && h >= 1) ? 8'(EXP_SHIFTED) : 8'd0);
    for (int v = 0; v < BROWS; v++)
      for (int h = 0; h < BCOLS; h++) begin
        read_map(h, v, got);
        check($sformatf("%s[%0d][%0d]", tag, v, h), got, exp_q.pop_front());
      end
    read_map(BCOLS, 1, got);
    check({tag, "_oob_col"}, got, 0);
    read_map(0, BROWS, got);
    check({tag, "_oob_row"}, got, 0);
  endtask

  task automatic run_frame(input string tag, input int stall_at, input bit poke_sad,
                           input int exp_read);
    int rd, fin, stall_left, budget, p;
    bit stalled, poked;
    logic [20:0] exp_addr;
    @(negedge clk);
    bus.buffer_ready = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    rd = 0; fin = 0; stall_left = 0; stalled = 0; poked = 0;
    p = stall_at - 1;
    exp_addr = {1'b1, 10'((p % NPIX) / 20), 10'((p % NPIX) % 20)};
    for (budget = 0; budget < 3000; budget++) begin
      if (state_LED == ST_IDLE) break;
      if (state_LED == ST_READ) rd++;
      if (state_LED == ST_FINALIZE) fin++;
      if (stall_left > 0) begin
        check({tag, "_stall_addr"}, {bus.image_sel, bus.buffer_vref, bus.buffer_href}, exp_addr);
        stall_left--;
        if (stall_left == 0) bus.buffer_ready = 1'b1;
      end else if (!stalled && stall_at > 0 && rd == stall_at) begin
        stalled = 1;
        stall_left = 10;
        bus.buffer_ready = 1'b0;
        check({tag, "_stall_addr0"}, {bus.image_sel, bus.buffer_vref, bus.buffer_href}, exp_addr);
      end
      enable = 1'b0;
      if (poke_sad && !poked && state_LED == ST_SAD) begin
        enable = 1'b1;
        poked = 1;
      end
      @(negedge clk);
    end
    enable = 1'b0;
    check({tag, "_done"}, (budget < 3000), 1);
    check({tag, "_read_cycles"}, rd, exp_read);
    check({tag, "_finalize_count"}, fin, 12);
    check({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    logic [7:0] got;
    reset = 1'b1; enable = 1'b0; mode = 0;
    bus.buffer_ready = 1'b0; bus.disp_href = '0; bus.disp_vref = '0;
    repeat (3) @(negedge clk);
    check("rst_state", state_LED, 0);
    check("rst_idle", idle, 1);
    check("rst_numblocks", numBlocks, 12);
    check("rst_maxd", maxd, 3);
    check("rst_mind", mind, 0);
    check("rst_counters", {dcnt, scnt, cdcnt}, 0);
    check("rst_addr", {bus.image_sel, bus.buffer_vref, bus.buffer_href}, 0);
    reset = 1'b0;
    check_map("rst_map", 0);

    mode = 0;
    run_frame("ident", 0, 0, 280);
    check_map("ident_map", 0);

    mode = 1;
    run_frame("tex", 0, 0, 280);
    check_map("tex_map", 1);

    run_frame("stall", 50, 0, 290);
    check_map("stall_map", 1);

    // abort mid-SAD with async reset
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 1000 && state_LED != ST_SAD; i++) @(negedge clk);
    check("abort_in_sad", state_LED, 3);
    reset = 1'b1;
    #1;
    check("abort_state", state_LED, 0);
    check("abort_idle", idle, 1);
    @(negedge clk);
    reset = 1'b0;
    check_map("abort_map", 0);
    run_frame("rerun", 0, 0, 280);
    check_map("rerun_map", 1);

    run_frame("poke", 0, 1, 280);
    check_map("poke_map", 1);

    read_map(1023, 1023, got);
    check("oob_max", got, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
